// File: rtl/tff_seq_ctrl.sv
// Command sequencer for a bank of toggle flip-flops: accepts TOGGLE/COUNT/CLEAR/NOP
// commands over valid/ready and drives the registered per-bit toggle vector.
module tff_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] t_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_TOGGLE = 2'b00;
    localparam logic [1:0] OP_COUNT  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] rem, rem_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] t_next;
    logic             accept;

    // Toggle vector that makes a TFF bank count up by one: bit i flips when all lower bits are set.
    function automatic logic [WIDTH-1:0] inc_vec(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             carry;
        r     = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            r[i]  = carry;
            carry = carry & v[i];
        end
        return r;
    endfunction

    assign cmd_ready = (state == IDLE) && rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_next = state;
        rem_next   = rem;
        op_next    = op_reg;
        t_next     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_next = cmd_op;
                    case (cmd_op)
                        OP_TOGGLE: begin
                            t_next     = cmd_mask;
                            rem_next   = CNT_W'(1);
                            state_next = EXEC;
                        end
                        OP_CLEAR: begin
                            t_next     = q;
                            rem_next   = CNT_W'(1);
                            state_next = EXEC;
                        end
                        OP_COUNT: begin
                            rem_next = cmd_len;
                            if (cmd_len == '0) begin
                                state_next = DONE;
                            end else begin
                                t_next     = inc_vec(q);
                                state_next = EXEC;
                            end
                        end
                        default: begin
                            rem_next   = '0;
                            state_next = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                rem_next = rem - CNT_W'(1);
                if (rem <= CNT_W'(1)) begin
                    state_next = DONE;
                end else if (op_reg == OP_COUNT) begin
                    // Next increment is computed from the bank value after this edge's toggle.
                    t_next = inc_vec(q ^ t_out);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rem    <= '0;
            op_reg <= '0;
            t_out  <= '0;
            q      <= '0;
        end else begin
            state  <= state_next;
            rem    <= rem_next;
            op_reg <= op_next;
            t_out  <= t_next;
            q      <= q ^ t_out;
        end
    end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed self-checking bench for tff_seq_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_tff_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    localparam logic [1:0] OP_TOGGLE = 2'b00;
    localparam logic [1:0] OP_COUNT  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] t_out;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    int checks;
    int failures;

    tff_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_len   (cmd_len),
        .t_out     (t_out),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one command for a single accept edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] mask, input logic [CNT_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_len   = len;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_mask  = '0;
        cmd_len   = '0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        logic done_seen;
        logic [WIDTH-1:0] exp_q;

        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_mask  = '0;
        cmd_len   = '0;

        // Reset
        repeat (2) @(negedge clk);
        checkOutput("rst_q", 32'(q), 32'h0);
        checkOutput("rst_t", 32'(t_out), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("rel_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);

        // TOGGLE 1010 twice
        applyStimulus(OP_TOGGLE, 4'b1010, '0);
        checkOutput("tog_t", 32'(t_out), 32'hA);
        checkOutput("tog_busy", 32'(busy), 32'h1);
        checkOutput("tog_ready", 32'(cmd_ready), 32'h0);
        checkOutput("tog_q0", 32'(q), 32'h0);
        @(negedge clk);
        checkOutput("tog_q1", 32'(q), 32'hA);
        checkOutput("tog_done", 32'(done), 32'h1);
        checkOutput("tog_t_off", 32'(t_out), 32'h0);
        checkOutput("tog_done_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        checkOutput("tog_done_clr", 32'(done), 32'h0);
        checkOutput("tog_idle", 32'(busy), 32'h0);
        checkOutput("tog_ready_back", 32'(cmd_ready), 32'h1);
        applyStimulus(OP_TOGGLE, 4'b1010, '0);
        @(negedge clk);
        checkOutput("tog2_q", 32'(q), 32'h0);
        checkOutput("tog2_done", 32'(done), 32'h1);
        @(negedge clk);

        // COUNT len=5 from 0
        applyStimulus(OP_COUNT, '0, 8'd5);
        busy_cnt = 0;
        done_cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            exp_q = (n <= 6) ? WIDTH'(n - 1) : WIDTH'(5);
            checkOutput($sformatf("cnt_q_%0d", n), 32'(q), 32'(exp_q));
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (n == 6) checkOutput("cnt_done_pos", 32'(done), 32'h1);
            if (n < 8) @(negedge clk);
        end
        checkOutput("cnt_busy_cycles", 32'(busy_cnt), 32'd6);
        checkOutput("cnt_done_count", 32'(done_cnt), 32'd1);

        // Move to q=E, then wrap with COUNT len=3
        applyStimulus(OP_COUNT, '0, 8'd9);
        repeat (9) @(negedge clk);
        checkOutput("pre_wrap_q", 32'(q), 32'hE);
        checkOutput("pre_wrap_done", 32'(done), 32'h1);
        @(negedge clk);
        applyStimulus(OP_COUNT, '0, 8'd3);
        checkOutput("wrap_t", 32'(t_out), 32'h1);
        @(negedge clk);
        checkOutput("wrap_qF", 32'(q), 32'hF);
        checkOutput("wrap_tF", 32'(t_out), 32'hF);
        @(negedge clk);
        checkOutput("wrap_q0", 32'(q), 32'h0);
        @(negedge clk);
        checkOutput("wrap_q1", 32'(q), 32'h1);
        checkOutput("wrap_done", 32'(done), 32'h1);
        @(negedge clk);

        // COUNT len=0 and NOP: done straight after accept, q untouched
        applyStimulus(OP_COUNT, '0, 8'd0);
        checkOutput("len0_done", 32'(done), 32'h1);
        checkOutput("len0_busy", 32'(busy), 32'h1);
        checkOutput("len0_t", 32'(t_out), 32'h0);
        checkOutput("len0_q", 32'(q), 32'h1);
        @(negedge clk);
        checkOutput("len0_ready", 32'(cmd_ready), 32'h1);
        checkOutput("len0_q_after", 32'(q), 32'h1);
        applyStimulus(OP_NOP, 4'b1111, 8'd4);
        checkOutput("nop_done", 32'(done), 32'h1);
        checkOutput("nop_q", 32'(q), 32'h1);
        @(negedge clk);

        // CLEAR from 1011 with cmd_valid held through busy
        applyStimulus(OP_TOGGLE, 4'b1010, '0);
        @(negedge clk);
        checkOutput("pre_clr_q", 32'(q), 32'hB);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        @(posedge clk);
        @(negedge clk);
        cmd_op   = OP_TOGGLE;
        cmd_mask = 4'b1111;
        checkOutput("clr_t", 32'(t_out), 32'hB);
        checkOutput("clr_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        checkOutput("clr_q", 32'(q), 32'h0);
        checkOutput("clr_done", 32'(done), 32'h1);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_mask  = '0;
        @(negedge clk);
        checkOutput("clr_no_reaccept", 32'(busy), 32'h0);
        @(negedge clk);
        checkOutput("clr_q_hold", 32'(q), 32'h0);

        // Reset in cycle 3 of COUNT len=10
        applyStimulus(OP_COUNT, '0, 8'd10);
        repeat (2) @(negedge clk);
        checkOutput("abort_pre_q", 32'(q), 32'h2);
        rst = 1'b0;
        #1;
        checkOutput("abort_q", 32'(q), 32'h0);
        checkOutput("abort_t", 32'(t_out), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'h0);
        checkOutput("abort_idle", 32'(busy), 32'h0);
        applyStimulus(OP_TOGGLE, 4'b0101, '0);
        @(negedge clk);
        checkOutput("post_abort_q", 32'(q), 32'h5);
        checkOutput("post_abort_done", 32'(done), 32'h1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
